hazard_match_gen: RTL and testbench

//  Producer side of the hazard-unit interface for the 5-stage pipelined ARM core.

---
 rtl/hazard_match_gen_pkg.sv | 35 +++
 rtl/hazard_match_gen_if.sv | 32 +++
 rtl/hazard_match_gen_sat_counter.sv | 19 +
 rtl/hazard_match_gen.sv | 96 +++++++++
 tb/tb_hazard_match_gen.sv | 216 +++++++++++++++++++++
 5 files changed

// File: rtl/hazard_match_gen_pkg.sv
// Shared types for the hazard-match producer: register address, per-stage control bundle, Match bit positions.
// Latency: n/a (types and one pure function).
// Backpressure: n/a.
package hazard_pkg;

    localparam int RA_W_DEF  = 4;
    localparam int CNT_W_DEF = 16;
    localparam int MATCH_W   = 5;

    localparam int MATCH_12D_E = 4;
    localparam int MATCH_1E_M  = 3;
    localparam int MATCH_2E_M  = 2;
    localparam int MATCH_1E_W  = 1;
    localparam int MATCH_2E_W  = 0;

    typedef logic [RA_W_DEF-1:0] reg_addr_t;

    typedef struct packed {
        logic      valid;
        logic      RegWrite;
        logic      MemtoReg;
        logic      PCSrc;
        reg_addr_t WA3;
    } pipe_ctl_t;

    // A failed condition turns the E instruction into a no-op for write purposes as it enters M.
    function automatic pipe_ctl_t qualify_cond(pipe_ctl_t c, logic cond);
        pipe_ctl_t q;
        q          = c;
        q.RegWrite = c.RegWrite & cond & c.valid;
        q.PCSrc    = c.PCSrc & cond & c.valid;
        return q;
    endfunction

endpackage

// File: rtl/hazard_match_gen_if.sv
// Decode-side inputs, hazard-unit controls and match outputs between the pipeline and the hazard unit.
// Latency: n/a (wires only).
// Backpressure: none; hazard unit reacts through FlushE/StallD.
interface hazard_match_gen_if #(
    parameter int RA_W = 4
) ();
    logic [RA_W-1:0] RA1D;
    logic [RA_W-1:0] RA2D;
    logic [RA_W-1:0] WA3D;
    logic            RegWriteD;
    logic            MemtoRegD;
    logic            PCSrcD;
    logic            CondExE;
    logic            FlushE;
    logic            StallD;
    logic [4:0]      Match;
    logic            RegWriteM;
    logic            RegWriteW;
    logic            MemtoRegE;
    logic            PCSrcW;
    logic            PCWrPendingF;

    modport master (
        output RA1D, RA2D, WA3D, RegWriteD, MemtoRegD, PCSrcD, CondExE, FlushE, StallD,
        input  Match, RegWriteM, RegWriteW, MemtoRegE, PCSrcW, PCWrPendingF
    );

    modport slave (
        input  RA1D, RA2D, WA3D, RegWriteD, MemtoRegD, PCSrcD, CondExE, FlushE, StallD,
        output Match, RegWriteM, RegWriteW, MemtoRegE, PCSrcW, PCWrPendingF
    );
endinterface

// File: rtl/hazard_match_gen_sat_counter.sv
// Saturating event counter with synchronous clear.
// Latency: count visible the cycle after the enabling event.
// Backpressure: none; sticks at all-ones.
module sat_counter #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             clr,
    input  logic             en,
    output logic [CNT_W-1:0] cnt
);
    always_ff @(posedge clk) begin
        if (clr) begin
            cnt <= '0;
        end else if (en && (cnt != '1)) begin
            cnt <= cnt + CNT_W'(1);
        end
    end
endmodule

// File: rtl/hazard_match_gen.sv
// Carries D-stage register addresses/controls through E/M/W and derives Match and write-qualifier flags for the hazard unit.
// Latency: Match[3:0] one cycle after D inputs; Match[4]/PCWrPendingF same cycle. Optional perf counters: HAZARD_PERF_CNT_EN.
// Backpressure: none; every stage advances every cycle, FlushE only bubbles E.
module hazard_match_gen
    import hazard_pkg::*;
#(
    parameter int RA_W  = RA_W_DEF,
    parameter int CNT_W = CNT_W_DEF
) (
    input  logic             clk,
    input  logic             reset,
    hazard_match_gen_if.slave hz,
    output logic [CNT_W-1:0] ldr_stall_cnt,
    output logic [CNT_W-1:0] flush_e_cnt
);
    pipe_ctl_t       ctl_e, ctl_m, ctl_w;
    logic [RA_W-1:0] ra1e, ra2e;
    logic [MATCH_W-1:0] match_raw;
    logic            pc_pending_raw;

    always_ff @(posedge clk) begin
        if (reset) begin
            ctl_e <= '0;
            ctl_m <= '0;
            ctl_w <= '0;
            ra1e  <= '0;
            ra2e  <= '0;
        end else begin
            if (hz.FlushE) begin
                ctl_e <= '0;
                ra1e  <= '0;
                ra2e  <= '0;
            end else begin
                ctl_e.valid    <= 1'b1;
                ctl_e.RegWrite <= hz.RegWriteD;
                ctl_e.MemtoReg <= hz.MemtoRegD;
                ctl_e.PCSrc    <= hz.PCSrcD;
                ctl_e.WA3      <= hz.WA3D;
                ra1e           <= hz.RA1D;
                ra2e           <= hz.RA2D;
            end
            ctl_m <= qualify_cond(ctl_e, hz.CondExE);
            ctl_w <= ctl_m;
        end
    end

    // Forwarding bits stay unqualified by RegWrite; the hazard unit ANDs RegWriteM/W itself.
    always_comb begin
        match_raw = '0;
        match_raw[MATCH_12D_E] = ctl_e.valid & ctl_e.RegWrite &
                                 ((hz.RA1D == ctl_e.WA3) | (hz.RA2D == ctl_e.WA3));
        match_raw[MATCH_1E_M]  = ctl_e.valid & ctl_m.valid & (ra1e == ctl_m.WA3);
        match_raw[MATCH_2E_M]  = ctl_e.valid & ctl_m.valid & (ra2e == ctl_m.WA3);
        match_raw[MATCH_1E_W]  = ctl_e.valid & ctl_w.valid & (ra1e == ctl_w.WA3);
        match_raw[MATCH_2E_W]  = ctl_e.valid & ctl_w.valid & (ra2e == ctl_w.WA3);
    end

    assign pc_pending_raw = (ctl_e.valid & ctl_e.PCSrc) | ctl_m.PCSrc;

    // Outputs are forced low during reset so the hazard unit never sees stale in-flight state.
    assign hz.Match        = reset ? '0 : match_raw;
    assign hz.RegWriteM    = ~reset & ctl_m.RegWrite;
    assign hz.RegWriteW    = ~reset & ctl_w.RegWrite;
    assign hz.MemtoRegE    = ~reset & ctl_e.MemtoReg;
    assign hz.PCSrcW       = ~reset & ctl_w.PCSrc;
    assign hz.PCWrPendingF = hz.PCSrcD | (~reset & pc_pending_raw);

`ifdef HAZARD_PERF_CNT_EN
    logic [CNT_W-1:0] stall_cnt_q, flush_cnt_q;
    logic             unused_ctl;

    sat_counter #(.CNT_W(CNT_W)) u_stall_cnt (
        .clk (clk),
        .clr (reset),
        .en  (hz.StallD),
        .cnt (stall_cnt_q)
    );

    sat_counter #(.CNT_W(CNT_W)) u_flush_cnt (
        .clk (clk),
        .clr (reset),
        .en  (hz.FlushE),
        .cnt (flush_cnt_q)
    );

    assign ldr_stall_cnt = reset ? '0 : stall_cnt_q;
    assign flush_e_cnt   = reset ? '0 : flush_cnt_q;
    assign unused_ctl    = ctl_m.MemtoReg ^ ctl_w.MemtoReg;
`else
    logic unused_ctl;
    assign ldr_stall_cnt = '0;
    assign flush_e_cnt   = '0;
    assign unused_ctl    = ctl_m.MemtoReg ^ ctl_w.MemtoReg ^ hz.StallD;
`endif

endmodule

// File: tb/tb_hazard_match_gen.sv
// Randomized plus scenario-steered bench: instruction-level pipeline model feeds a scoreboard queue, monitor compares each cycle.
module tb_hazard_match_gen;
    localparam int RA_W  = 4;
    localparam int CNT_W = 4;
    localparam int CNT_MAX = (1 << CNT_W) - 1;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic [CNT_W-1:0] ldr_stall_cnt, flush_e_cnt;

    always #5 clk = ~clk;

    hazard_match_gen_if #(.RA_W(RA_W)) hz ();

    hazard_match_gen #(.RA_W(RA_W), .CNT_W(CNT_W)) dut (
        .clk           (clk),
        .reset         (reset),
        .hz            (hz),
        .ldr_stall_cnt (ldr_stall_cnt),
        .flush_e_cnt   (flush_e_cnt)
    );

    typedef struct {
        bit v;
        bit rw;
        bit ld;
        bit pc;
        int wa;
        int ra1;
        int ra2;
    } instr_t;

    typedef struct {
        int match;
        int rwm;
        int rww;
        int mtre;
        int pcsw;
        int pcwp;
        int scnt;
        int fcnt;
    } exp_t;

    instr_t pipe_e, pipe_m, pipe_w;
    int     stall_n, flush_n;
    exp_t   exp_q[$];
    int     n_checks = 0;
    int     n_pass = 0;
    bit     stim_done = 1'b0;

    task automatic check(string name, int act, int expv);
        n_checks++;
        if (act == expv) n_pass++;
        else $display("FAIL %s: got %0d expected %0d at %0t", name, act, expv, $time);
    endtask

    // One cycle: apply inputs, record what the outputs must be this cycle, then retire the model by one clock.
    task automatic drive(bit rst, int ra1, int ra2, int wa3, bit rw, bit ld, bit pc,
                         bit cond, bit flush, bit stall);
        exp_t   e;
        instr_t nw;
        @(posedge clk);
        #1;
        reset        = rst;
        hz.RA1D      = RA_W'(ra1);
        hz.RA2D      = RA_W'(ra2);
        hz.WA3D      = RA_W'(wa3);
        hz.RegWriteD = rw;
        hz.MemtoRegD = ld;
        hz.PCSrcD    = pc;
        hz.CondExE   = cond;
        hz.FlushE    = flush;
        hz.StallD    = stall;

        e = '{default: 0};
        e.pcwp = pc;
        if (!rst) begin
            if (pipe_e.v && pipe_e.rw && (ra1 == pipe_e.wa || ra2 == pipe_e.wa)) e.match += 16;
            if (pipe_e.v && pipe_m.v && pipe_e.ra1 == pipe_m.wa) e.match += 8;
            if (pipe_e.v && pipe_m.v && pipe_e.ra2 == pipe_m.wa) e.match += 4;
            if (pipe_e.v && pipe_w.v && pipe_e.ra1 == pipe_w.wa) e.match += 2;
            if (pipe_e.v && pipe_w.v && pipe_e.ra2 == pipe_w.wa) e.match += 1;
            e.rwm  = pipe_m.rw;
            e.rww  = pipe_w.rw;
            e.mtre = pipe_e.ld;
            e.pcsw = pipe_w.pc;
            e.pcwp = (pc || (pipe_e.v && pipe_e.pc) || pipe_m.pc) ? 1 : 0;
`ifdef HAZARD_PERF_CNT_EN
            e.scnt = stall_n;
            e.fcnt = flush_n;
`endif
        end
        exp_q.push_back(e);

        if (rst) begin
            pipe_e = '{default: 0};
            pipe_m = '{default: 0};
            pipe_w = '{default: 0};
            stall_n = 0;
            flush_n = 0;
        end else begin
            pipe_w = pipe_m;
            pipe_m = pipe_e;
            // An instruction whose condition fails in E writes nothing further down the pipe.
            if (!(cond && pipe_e.v)) begin
                pipe_m.rw = 1'b0;
                pipe_m.pc = 1'b0;
            end
            nw = '{default: 0};
            if (!flush) nw = '{v: 1'b1, rw: rw, ld: ld, pc: pc, wa: wa3, ra1: ra1, ra2: ra2};
            pipe_e = nw;
            if (stall && stall_n < CNT_MAX) stall_n++;
            if (flush && flush_n < CNT_MAX) flush_n++;
        end
    endtask

    task automatic idle(bit cond);
        drive(1'b0, 7, 8, 9, 1'b0, 1'b0, 1'b0, cond, 1'b0, 1'b0);
    endtask

    function automatic int rand_reg();
        return ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 15)) : int'($urandom_range(0, 3));
    endfunction

    // Monitor: outputs are meaningful every cycle, so one expectation is consumed per falling edge.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check("Match",         int'(hz.Match),        e.match);
                check("RegWriteM",     int'(hz.RegWriteM),    e.rwm);
                check("RegWriteW",     int'(hz.RegWriteW),    e.rww);
                check("MemtoRegE",     int'(hz.MemtoRegE),    e.mtre);
                check("PCSrcW",        int'(hz.PCSrcW),       e.pcsw);
                check("PCWrPendingF",  int'(hz.PCWrPendingF), e.pcwp);
                check("ldr_stall_cnt", int'(ldr_stall_cnt),   e.scnt);
                check("flush_e_cnt",   int'(flush_e_cnt),     e.fcnt);
            end
        end
    end

    initial begin
        pipe_e = '{default: 0};
        pipe_m = '{default: 0};
        pipe_w = '{default: 0};
        stall_n = 0;
        flush_n = 0;
        hz.RA1D = '0; hz.RA2D = '0; hz.WA3D = '0;
        hz.RegWriteD = 1'b0; hz.MemtoRegD = 1'b0; hz.PCSrcD = 1'b0;
        hz.CondExE = 1'b1; hz.FlushE = 1'b0; hz.StallD = 1'b0;

        // Reset with PCSrcD toggling, then idle.
        drive(1'b1, 1, 2, 3, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
        drive(1'b1, 1, 2, 3, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1);
        idle(1'b1);
        idle(1'b1);

        // ADD r1 followed by two readers of r1: E->D, M and W forwarding windows.
        drive(1'b0, 0, 0, 1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        drive(1'b0, 1, 3, 5, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        drive(1'b0, 1, 3, 6, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        idle(1'b1);
        idle(1'b1);

        // LDR r2 then a reader of r2 that the hazard unit flushes out of E.
        drive(1'b0, 0, 0, 2, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
        drive(1'b0, 4, 2, 6, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1);
        drive(1'b0, 4, 2, 6, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        idle(1'b1);
        idle(1'b1);

        // Condition-failed write, then a PC write that passes its condition.
        drive(1'b0, 0, 0, 4, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        drive(1'b0, 4, 0, 5, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        drive(1'b0, 0, 0, 15, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 4; i++) idle(1'b1);

        // Reset overrides flush with a valid instruction in E, r15 as destination.
        drive(1'b0, 15, 15, 15, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
        drive(1'b1, 15, 15, 3, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
        idle(1'b1);
        idle(1'b1);

        // Long stall to reach counter saturation.
        for (int i = 0; i < 20; i++)
            drive(1'b0, 1, 2, 3, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1);

        for (int i = 0; i < 400; i++) begin
            drive(($urandom_range(0, 99) < 2), rand_reg(), rand_reg(), rand_reg(),
                  ($urandom_range(0, 99) < 70), ($urandom_range(0, 99) < 25),
                  ($urandom_range(0, 99) < 10), ($urandom_range(0, 99) < 80),
                  ($urandom_range(0, 99) < 15), ($urandom_range(0, 99) < 30));
        end
        stim_done = 1'b1;
    end

    initial begin
        wait (stim_done);
        for (int i = 0; i < 20 && exp_q.size() > 0; i++) @(posedge clk);
        if (exp_q.size() > 0) begin
            n_checks++;
            $display("FAIL drain: %0d expectations left, required 0", exp_q.size());
        end
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: stimulus did not complete, required completion");
        $display("%0d/%0d checks passed", n_pass, n_checks + 1);
        $fatal(1, "timeout");
    end
endmodule
